// File: rtl/decode_issue_pkg.sv
// decode_issue_pkg: shared widths for the decode-stage operand collector.
// REGSZ is the GPR width, XERCRSZ the XER/CR width.
package decode_issue_pkg;
    localparam int REGSZ   = 64;
    localparam int XERCRSZ = 32;
endpackage

// File: rtl/decode_issue_if.sv
// decode_issue_if: decode/bypass/EX signals around decode_issue.
// slave = decode_issue side, master = surrounding pipeline side.
interface decode_issue_if
    import decode_issue_pkg::*;
#(
    parameter int PAYLOAD_W = 96
);
    logic                 in_valid;
    logic [PAYLOAD_W-1:0] in_payload;
    logic                 in_need_a;
    logic                 in_need_b;
    logic                 in_need_c;
    logic                 in_need_xercr;
    logic                 in_stall;
    logic                 bp_enable;
    logic [REGSZ-1:0]     rf_a_val;
    logic [REGSZ-1:0]     rf_b_val;
    logic [REGSZ-1:0]     rf_c_val;
    logic [XERCRSZ-1:0]   rf_xercr_val;
    logic                 gpr_a_bypassed;
    logic                 gpr_b_bypassed;
    logic                 gpr_c_bypassed;
    logic [REGSZ-1:0]     gpr_a_bypass_val;
    logic [REGSZ-1:0]     gpr_b_bypass_val;
    logic [REGSZ-1:0]     gpr_c_bypass_val;
    logic                 xercr_bypassed;
    logic [XERCRSZ-1:0]   xercr_bypass_val;
    logic                 gpr_a_busy;
    logic                 gpr_b_busy;
    logic                 gpr_c_busy;
    logic                 xercr_busy;
    logic                 flush;
    logic                 out_valid;
    logic                 out_stall;
    logic [PAYLOAD_W-1:0] out_payload;
    logic [REGSZ-1:0]     out_op_a;
    logic [REGSZ-1:0]     out_op_b;
    logic [REGSZ-1:0]     out_op_c;
    logic [XERCRSZ-1:0]   out_xercr;
    logic [31:0]          stat_hazard_cycles;
    logic [31:0]          stat_backpressure_cycles;

    modport slave (
        input  in_valid, in_payload,
        input  in_need_a, in_need_b, in_need_c, in_need_xercr,
        output in_stall, bp_enable,
        input  rf_a_val, rf_b_val, rf_c_val, rf_xercr_val,
        input  gpr_a_bypassed, gpr_b_bypassed, gpr_c_bypassed,
        input  gpr_a_bypass_val, gpr_b_bypass_val, gpr_c_bypass_val,
        input  xercr_bypassed, xercr_bypass_val,
        input  gpr_a_busy, gpr_b_busy, gpr_c_busy, xercr_busy,
        input  flush, out_stall,
        output out_valid, out_payload,
        output out_op_a, out_op_b, out_op_c, out_xercr,
        output stat_hazard_cycles, stat_backpressure_cycles
    );

    modport master (
        output in_valid, in_payload,
        output in_need_a, in_need_b, in_need_c, in_need_xercr,
        input  in_stall, bp_enable,
        output rf_a_val, rf_b_val, rf_c_val, rf_xercr_val,
        output gpr_a_bypassed, gpr_b_bypassed, gpr_c_bypassed,
        output gpr_a_bypass_val, gpr_b_bypass_val, gpr_c_bypass_val,
        output xercr_bypassed, xercr_bypass_val,
        output gpr_a_busy, gpr_b_busy, gpr_c_busy, xercr_busy,
        output flush, out_stall,
        input  out_valid, out_payload,
        input  out_op_a, out_op_b, out_op_c, out_xercr,
        input  stat_hazard_cycles, stat_backpressure_cycles
    );
endinterface

// File: rtl/decode_issue_operand.sv
// decode_issue_operand: readiness and value select for one source operand.
// Ports: i_need/i_bypassed/i_busy, i_bypass_val, i_rf_val -> o_ready, o_val.
module decode_issue_operand #(
    parameter int W = 64
) (
    input  logic         i_need,
    input  logic         i_bypassed,
    input  logic         i_busy,
    input  logic [W-1:0] i_bypass_val,
    input  logic [W-1:0] i_rf_val,
    output logic         o_ready,
    output logic [W-1:0] o_val
);
    assign o_ready = !i_need || i_bypassed || !i_busy;

    // Unused operands are zeroed so EX never sees stale data.
    assign o_val = !i_need ? '0 :
                   (i_bypassed ? i_bypass_val : i_rf_val);
endmodule

// File: rtl/decode_issue.sv
// decode_issue: operand collector + one-entry issue register into EX.
// Ports: clk, reset (sync, active-high), io (decode_issue_if.slave).
// Optional macro DECODE_ISSUE_STATS_EN enables hazard/backpressure counters.
module decode_issue
    import decode_issue_pkg::*;
#(
    parameter int PAYLOAD_W = 96,
    parameter int RF_LAT_OK = 1
) (
    input logic           clk,
    input logic           reset,
    decode_issue_if.slave io
);
    // Only a combinational register file is supported.
    localparam bit LP_RF_COMB = (RF_LAT_OK == 1);

    logic                 w_rdy_a, w_rdy_b, w_rdy_c, w_rdy_x;
    logic [REGSZ-1:0]     w_val_a, w_val_b, w_val_c;
    logic [XERCRSZ-1:0]   w_val_x;
    logic                 w_all_rdy;
    logic                 w_space;
    logic                 w_fire;

    logic                 r_valid;
    logic [PAYLOAD_W-1:0] r_payload;
    logic [REGSZ-1:0]     r_op_a, r_op_b, r_op_c;
    logic [XERCRSZ-1:0]   r_xercr;

    decode_issue_operand #(.W(REGSZ)) u_op_a (
        .i_need(io.in_need_a), .i_bypassed(io.gpr_a_bypassed),
        .i_busy(io.gpr_a_busy), .i_bypass_val(io.gpr_a_bypass_val),
        .i_rf_val(io.rf_a_val), .o_ready(w_rdy_a), .o_val(w_val_a)
    );
    decode_issue_operand #(.W(REGSZ)) u_op_b (
        .i_need(io.in_need_b), .i_bypassed(io.gpr_b_bypassed),
        .i_busy(io.gpr_b_busy), .i_bypass_val(io.gpr_b_bypass_val),
        .i_rf_val(io.rf_b_val), .o_ready(w_rdy_b), .o_val(w_val_b)
    );
    decode_issue_operand #(.W(REGSZ)) u_op_c (
        .i_need(io.in_need_c), .i_bypassed(io.gpr_c_bypassed),
        .i_busy(io.gpr_c_busy), .i_bypass_val(io.gpr_c_bypass_val),
        .i_rf_val(io.rf_c_val), .o_ready(w_rdy_c), .o_val(w_val_c)
    );
    decode_issue_operand #(.W(XERCRSZ)) u_op_x (
        .i_need(io.in_need_xercr), .i_bypassed(io.xercr_bypassed),
        .i_busy(io.xercr_busy), .i_bypass_val(io.xercr_bypass_val),
        .i_rf_val(io.rf_xercr_val), .o_ready(w_rdy_x), .o_val(w_val_x)
    );

    assign w_all_rdy = w_rdy_a && w_rdy_b && w_rdy_c && w_rdy_x;
    assign w_space   = !r_valid || !io.out_stall;
    assign w_fire    = io.in_valid && !io.flush && w_all_rdy
                       && w_space && LP_RF_COMB;

    assign io.in_stall  = io.in_valid && !io.flush && !w_fire;
    assign io.bp_enable = io.in_valid;

    // Data moves only on fire, so a held packet is never disturbed.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid   <= 1'b0;
            r_payload <= '0;
            r_op_a    <= '0;
            r_op_b    <= '0;
            r_op_c    <= '0;
            r_xercr   <= '0;
        end else if (io.flush) begin
            r_valid <= 1'b0;
        end else if (w_fire) begin
            r_valid   <= 1'b1;
            r_payload <= io.in_payload;
            r_op_a    <= w_val_a;
            r_op_b    <= w_val_b;
            r_op_c    <= w_val_c;
            r_xercr   <= w_val_x;
        end else if (r_valid && !io.out_stall) begin
            r_valid <= 1'b0;
        end
    end

    assign io.out_valid   = r_valid;
    assign io.out_payload = r_payload;
    assign io.out_op_a    = r_op_a;
    assign io.out_op_b    = r_op_b;
    assign io.out_op_c    = r_op_c;
    assign io.out_xercr   = r_xercr;

`ifdef DECODE_ISSUE_STATS_EN
    logic        w_hazard;
    logic        w_backp;
    logic [31:0] r_hazard_cnt;
    logic [31:0] r_backp_cnt;

    // A cycle that is both hazard and backpressure counts as hazard.
    assign w_hazard = io.in_valid && !io.flush && !w_all_rdy;
    assign w_backp  = io.in_valid && w_all_rdy && !w_space && !w_hazard;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_hazard_cnt <= '0;
            r_backp_cnt  <= '0;
        end else begin
            if (w_hazard) r_hazard_cnt <= r_hazard_cnt + 32'd1;
            if (w_backp)  r_backp_cnt  <= r_backp_cnt + 32'd1;
        end
    end

    assign io.stat_hazard_cycles       = r_hazard_cnt;
    assign io.stat_backpressure_cycles = r_backp_cnt;
`else
    assign io.stat_hazard_cycles       = 32'd0;
    assign io.stat_backpressure_cycles = 32'd0;
`endif
endmodule

// File: tb/tb_decode_issue.sv
// tb_decode_issue: directed and random stimulus against a reference model.
// Optional macro DECODE_ISSUE_STATS_EN also checks the statistic counters.
module tb_decode_issue;
    import decode_issue_pkg::*;

    localparam int PW = 96;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    decode_issue_if #(.PAYLOAD_W(PW)) io ();

    decode_issue #(.PAYLOAD_W(PW), .RF_LAT_OK(1)) dut (
        .clk(clk),
        .reset(reset),
        .io(io)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference state: what EX should be seeing, plus counters.
    logic          m_valid;
    logic [PW-1:0] m_pay;
    logic [63:0]   m_a, m_b, m_c;
    logic [31:0]   m_x;
    logic [31:0]   m_haz;
    logic [31:0]   m_bkp;

    task automatic check(input string tag,
                         input logic [127:0] act,
                         input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [63:0] pick(input logic need,
                                         input logic byp,
                                         input logic [63:0] bv,
                                         input logic [63:0] rv);
        if (!need) return 64'd0;
        return byp ? bv : rv;
    endfunction

    task automatic idle_inputs();
        io.in_valid = 0; io.in_payload = '0;
        io.in_need_a = 0; io.in_need_b = 0;
        io.in_need_c = 0; io.in_need_xercr = 0;
        io.rf_a_val = '0; io.rf_b_val = '0;
        io.rf_c_val = '0; io.rf_xercr_val = '0;
        io.gpr_a_bypassed = 0; io.gpr_b_bypassed = 0;
        io.gpr_c_bypassed = 0; io.xercr_bypassed = 0;
        io.gpr_a_bypass_val = '0; io.gpr_b_bypass_val = '0;
        io.gpr_c_bypass_val = '0; io.xercr_bypass_val = '0;
        io.gpr_a_busy = 0; io.gpr_b_busy = 0;
        io.gpr_c_busy = 0; io.xercr_busy = 0;
        io.flush = 0; io.out_stall = 0;
    endtask

    // One cycle: check combinational outputs, clock, then check registers.
    task automatic step();
        logic ok, room, go, haz;
        #1;
        ok = 1'b1;
        if (io.in_need_a && io.gpr_a_busy && !io.gpr_a_bypassed) ok = 0;
        if (io.in_need_b && io.gpr_b_busy && !io.gpr_b_bypassed) ok = 0;
        if (io.in_need_c && io.gpr_c_busy && !io.gpr_c_bypassed) ok = 0;
        if (io.in_need_xercr && io.xercr_busy && !io.xercr_bypassed) ok = 0;
        room = !(m_valid && io.out_stall);
        go = io.in_valid && !io.flush && ok && room;
        haz = io.in_valid && !io.flush && !ok;
        check("in_stall", 128'(io.in_stall),
              128'(io.in_valid && !io.flush && !go));
        check("bp_enable", 128'(io.bp_enable), 128'(io.in_valid));
        @(posedge clk);
        if (reset) begin
            m_valid = 0; m_pay = '0;
            m_a = '0; m_b = '0; m_c = '0; m_x = '0;
            m_haz = 0; m_bkp = 0;
        end else begin
            if (haz) m_haz = m_haz + 1;
            else if (io.in_valid && ok && !room) m_bkp = m_bkp + 1;
            if (io.flush) m_valid = 0;
            else if (go) begin
                m_valid = 1;
                m_pay = io.in_payload;
                m_a = pick(io.in_need_a, io.gpr_a_bypassed,
                           io.gpr_a_bypass_val, io.rf_a_val);
                m_b = pick(io.in_need_b, io.gpr_b_bypassed,
                           io.gpr_b_bypass_val, io.rf_b_val);
                m_c = pick(io.in_need_c, io.gpr_c_bypassed,
                           io.gpr_c_bypass_val, io.rf_c_val);
                m_x = 32'(pick(io.in_need_xercr, io.xercr_bypassed,
                               64'(io.xercr_bypass_val),
                               64'(io.rf_xercr_val)));
            end else if (!io.out_stall) m_valid = 0;
        end
        @(negedge clk);
        check("out_valid", 128'(io.out_valid), 128'(m_valid));
        check("out_payload", 128'(io.out_payload), 128'(m_pay));
        check("out_op_a", 128'(io.out_op_a), 128'(m_a));
        check("out_op_b", 128'(io.out_op_b), 128'(m_b));
        check("out_op_c", 128'(io.out_op_c), 128'(m_c));
        check("out_xercr", 128'(io.out_xercr), 128'(m_x));
`ifdef DECODE_ISSUE_STATS_EN
        check("stat_haz", 128'(io.stat_hazard_cycles), 128'(m_haz));
        check("stat_bkp", 128'(io.stat_backpressure_cycles), 128'(m_bkp));
`else
        check("stat_haz", 128'(io.stat_hazard_cycles), 128'd0);
        check("stat_bkp", 128'(io.stat_backpressure_cycles), 128'd0);
`endif
    endtask

    function automatic logic [63:0] r64();
        return {$urandom, $urandom};
    endfunction

    function automatic logic pct(input int p);
        return ($urandom_range(99) < p);
    endfunction

    initial begin
        checks = 0;
        errors = 0;
        m_valid = 0; m_pay = '0;
        m_a = '0; m_b = '0; m_c = '0; m_x = '0;
        m_haz = 0; m_bkp = 0;
        idle_inputs();
        reset = 1;
        @(negedge clk);
        step();
        step();
        reset = 0;
        check("rst_valid", 128'(io.out_valid), 128'd0);

        // Simple issue.
        io.in_valid = 1; io.in_payload = 96'hABC;
        io.in_need_a = 1; io.rf_a_val = 64'h11;
        step();
        check("simple_a", 128'(io.out_op_a), 128'h11);
        check("simple_v", 128'(io.out_valid), 128'd1);

        // Bypass wins over the register file.
        idle_inputs();
        io.in_valid = 1; io.in_need_b = 1;
        io.gpr_b_busy = 1; io.gpr_b_bypassed = 1;
        io.gpr_b_bypass_val = 64'hDEAD; io.rf_b_val = 64'h5;
        step();
        check("bypass_b", 128'(io.out_op_b), 128'hDEAD);

        // Hazard stall for three cycles.
        idle_inputs();
        io.in_valid = 1; io.in_need_c = 1; io.gpr_c_busy = 1;
        io.gpr_c_bypassed = 0; io.gpr_c_bypass_val = 64'h99;
        for (int i = 0; i < 3; i++) step();
        check("haz_v", 128'(io.out_valid), 128'd0);
        io.gpr_c_busy = 0; io.rf_c_val = 64'h7;
        step();
        check("haz_c", 128'(io.out_op_c), 128'h7);

        // Backpressure with a ready instruction waiting.
        io.in_payload = 96'h1; io.rf_c_val = 64'h21;
        io.out_stall = 1;
        step();
        io.in_payload = 96'h2; io.rf_c_val = 64'h22;
        step();
        check("bkp_hold", 128'(io.out_op_c), 128'h7);
        io.out_stall = 0;
        step();
        check("bkp_new", 128'(io.out_op_c), 128'h22);

        // Flush while both sides are valid.
        io.in_payload = 96'h3;
        io.flush = 1;
        step();
        check("flush_v", 128'(io.out_valid), 128'd0);
        io.flush = 0;
        step();

        // Reset while the issue register is back-pressured.
        io.out_stall = 1;
        step();
        reset = 1;
        step();
        reset = 0;
        check("rst_bkp", 128'(io.out_valid), 128'd0);

        // Random traffic.
        for (int n = 0; n < 3000; n++) begin
            io.in_valid = pct(80);
            io.in_payload = {$urandom, r64()};
            io.in_need_a = pct(70); io.in_need_b = pct(70);
            io.in_need_c = pct(70); io.in_need_xercr = pct(50);
            io.rf_a_val = r64(); io.rf_b_val = r64();
            io.rf_c_val = r64(); io.rf_xercr_val = $urandom;
            io.gpr_a_bypassed = pct(30); io.gpr_b_bypassed = pct(30);
            io.gpr_c_bypassed = pct(30); io.xercr_bypassed = pct(30);
            io.gpr_a_bypass_val = r64(); io.gpr_b_bypass_val = r64();
            io.gpr_c_bypass_val = r64(); io.xercr_bypass_val = $urandom;
            io.gpr_a_busy = pct(30); io.gpr_b_busy = pct(30);
            io.gpr_c_busy = pct(30); io.xercr_busy = pct(30);
            io.flush = pct(5);
            io.out_stall = pct(40);
            reset = pct(2);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
